// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

    // Sequencer states: IDLE waits for a trap or MRET, W_* write the trap CSRs,
    // R_* read the vector/return address, REDIR issues the PC redirect.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_W_EPC   = 3'd1,
        ST_W_CAUSE = 3'd2,
        ST_W_TVAL  = 3'd3,
        ST_R_TVEC  = 3'd4,
        ST_R_EPC   = 3'd5,
        ST_REDIR   = 3'd6
    } trap_state_e;

    // Exception and interrupt cause codes
    localparam int unsigned CAUSE_ILLEGAL_INSN = 2;
    localparam int unsigned CAUSE_ECALL_M      = 11;
    localparam int unsigned IRQ_M_EXT          = 11;

    // mtvec[1:0] mode field encodings
    localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_NUM_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_NUM_MEPC   = 12'h341;
    localparam logic [11:0] CSR_NUM_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_NUM_MTVAL  = 12'h343;

endpackage

// File: rtl/trap_controller.sv
// Machine-mode trap/MRET sequencer: writes mepc/mcause/mtval on a trap,
// reads mtvec or mepc, redirects the PC and owns mstatus.MIE/MPIE.
module trap_controller
    import trap_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 5
) (
    input  logic               i_Clock,
    input  logic               i_Reset_n,
    input  logic               i_ExcValid,
    input  logic [CAUSE_W-1:0] i_ExcCause,
    input  logic [XLEN-1:0]    i_ExcPc,
    input  logic [XLEN-1:0]    i_ExcTval,
    input  logic               i_IrqPending,
    input  logic [XLEN-1:0]    i_IrqPc,
    input  logic               i_MretValid,
    output logic               o_Stall,
    output logic               o_Flush,
    output logic               o_CsrWriteEnable,
    output logic [11:0]        o_CsrNumber,
    output logic [XLEN-1:0]    o_CsrWriteData,
    input  logic [XLEN-1:0]    i_CsrReadData,
    output logic               o_RedirectValid,
    output logic [XLEN-1:0]    o_RedirectPc,
    output logic               o_MstatusMie
);

    trap_state_e       state_q, state_d;
    logic              mie_q, mpie_q;
    logic              is_mret_q;
    logic              is_irq_q;
    logic [XLEN-1:0]   epc_q, cause_q, tval_q, target_q;
    logic              take_exc, take_irq, take_mret, take_trap;

    // Trap handler address from mtvec; vectoring applies to interrupts only,
    // reserved modes 2/3 behave as direct, and the sum wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] tvec_target(input logic [XLEN-1:0]    tvec,
                                                    input logic               irq,
                                                    input logic [CAUSE_W-1:0] code);
        logic [XLEN-1:0] base;
        base = {tvec[XLEN-1:2], 2'b00};
        if (irq && (tvec[1:0] == MTVEC_MODE_VECTORED))
            return base + (XLEN'(code) << 2);
        return base;
    endfunction

    // Acceptance in IDLE: exception beats enabled interrupt beats MRET
    always_comb begin
        take_exc  = (state_q == ST_IDLE) && i_ExcValid;
        take_irq  = (state_q == ST_IDLE) && !i_ExcValid && i_IrqPending && mie_q;
        take_mret = (state_q == ST_IDLE) && !i_ExcValid && !(i_IrqPending && mie_q) && i_MretValid;
        take_trap = take_exc || take_irq;
    end

    // Next-state and Moore outputs of the sequencer
    always_comb begin
        state_d          = state_q;
        o_Stall          = 1'b0;
        o_Flush          = 1'b0;
        o_CsrWriteEnable = 1'b0;
        o_CsrNumber      = 12'h000;
        o_CsrWriteData   = '0;
        o_RedirectValid  = 1'b0;
        o_RedirectPc     = '0;
        case (state_q)
            ST_IDLE: begin
                if (take_trap)
                    state_d = ST_W_EPC;
                else if (take_mret)
                    state_d = ST_R_EPC;
            end
            ST_W_EPC: begin
                o_Flush          = 1'b1;
                o_Stall          = 1'b1;
                o_CsrWriteEnable = 1'b1;
                o_CsrNumber      = CSR_NUM_MEPC;
                o_CsrWriteData   = epc_q;
                state_d          = ST_W_CAUSE;
            end
            ST_W_CAUSE: begin
                o_Stall          = 1'b1;
                o_CsrWriteEnable = 1'b1;
                o_CsrNumber      = CSR_NUM_MCAUSE;
                o_CsrWriteData   = cause_q;
                state_d          = ST_W_TVAL;
            end
            ST_W_TVAL: begin
                o_Stall          = 1'b1;
                o_CsrWriteEnable = 1'b1;
                o_CsrNumber      = CSR_NUM_MTVAL;
                o_CsrWriteData   = tval_q;
                state_d          = ST_R_TVEC;
            end
            ST_R_TVEC: begin
                o_Stall     = 1'b1;
                o_CsrNumber = CSR_NUM_MTVEC;
                state_d     = ST_REDIR;
            end
            ST_R_EPC: begin
                o_Flush     = 1'b1;
                o_Stall     = 1'b1;
                o_CsrNumber = CSR_NUM_MEPC;
                state_d     = ST_REDIR;
            end
            ST_REDIR: begin
                o_RedirectValid = 1'b1;
                o_RedirectPc    = target_q;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state: FSM register, interrupt-enable stack, MRET marker
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= ST_IDLE;
            mie_q     <= 1'b0;
            mpie_q    <= 1'b0;
            is_mret_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take_trap) begin
                mpie_q    <= mie_q;
                mie_q     <= 1'b0;
                is_mret_q <= 1'b0;
            end else if (take_mret) begin
                is_mret_q <= 1'b1;
            end else if ((state_q == ST_REDIR) && is_mret_q) begin
                mie_q     <= mpie_q;
                mpie_q    <= 1'b1;
                is_mret_q <= 1'b0;
            end
        end
    end

    // Trap context and redirect target; only consumed after being loaded
    always_ff @(posedge i_Clock) begin
        if (take_trap) begin
            is_irq_q <= take_irq;
            if (take_exc) begin
                epc_q   <= i_ExcPc;
                cause_q <= XLEN'(i_ExcCause);
                tval_q  <= i_ExcTval;
            end else begin
                epc_q   <= i_IrqPc;
                cause_q <= {1'b1, (XLEN-1)'(IRQ_M_EXT)};
                tval_q  <= '0;
            end
        end
        if (state_q == ST_R_TVEC)
            target_q <= tvec_target(i_CsrReadData, is_irq_q, cause_q[CAUSE_W-1:0]);
        else if (state_q == ST_R_EPC)
            target_q <= i_CsrReadData & ~XLEN'(3);
    end

    assign o_MstatusMie = mie_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exc_valid = 1'b0;
    logic [4:0]  exc_cause = '0;
    logic [31:0] exc_pc = '0;
    logic [31:0] exc_tval = '0;
    logic        irq_pending = 1'b0;
    logic [31:0] irq_pc = '0;
    logic        mret_valid = 1'b0;
    logic        stall, flush, csr_we, redir_valid, mie;
    logic [11:0] csr_num;
    logic [31:0] csr_wdata, csr_rdata, redir_pc;

    // Minimal CSR file model: only mtvec and mepc are read by the DUT
    logic [31:0] csr_mtvec = '0;
    logic [31:0] csr_mepc = '0;

    int checks = 0;
    int errors = 0;

    // Per-cycle observations, index 0 = cycle after the accept edge
    logic        ob_we[0:15];
    logic [11:0] ob_num[0:15];
    logic [31:0] ob_wd[0:15];
    logic        ob_fl[0:15];
    logic        ob_st[0:15];
    logic        ob_rv[0:15];
    logic [31:0] ob_rpc[0:15];
    logic        ob_mie[0:15];

    trap_controller #(.XLEN(32), .CAUSE_W(5)) dut (
        .i_Clock          (clk),
        .i_Reset_n        (rst_n),
        .i_ExcValid       (exc_valid),
        .i_ExcCause       (exc_cause),
        .i_ExcPc          (exc_pc),
        .i_ExcTval        (exc_tval),
        .i_IrqPending     (irq_pending),
        .i_IrqPc          (irq_pc),
        .i_MretValid      (mret_valid),
        .o_Stall          (stall),
        .o_Flush          (flush),
        .o_CsrWriteEnable (csr_we),
        .o_CsrNumber      (csr_num),
        .o_CsrWriteData   (csr_wdata),
        .i_CsrReadData    (csr_rdata),
        .o_RedirectValid  (redir_valid),
        .o_RedirectPc     (redir_pc),
        .o_MstatusMie     (mie)
    );

    always #5 clk = ~clk;

    assign csr_rdata = (csr_num == 12'h305) ? csr_mtvec :
                       (csr_num == 12'h341) ? csr_mepc  : 32'h0;

    // Let the accept edge pass, drop the request pulses, record n cycles
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            exc_valid   = 1'b0;
            mret_valid  = 1'b0;
            irq_pending = 1'b0;
            @(negedge clk);
            ob_we[i]  = csr_we;
            ob_num[i] = csr_num;
            ob_wd[i]  = csr_wdata;
            ob_fl[i]  = flush;
            ob_st[i]  = stall;
            ob_rv[i]  = redir_valid;
            ob_rpc[i] = redir_pc;
            ob_mie[i] = mie;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        exc_valid = 1'b1;
        exc_cause = 5'd2;
        exc_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({csr_we, flush, stall, redir_valid, mie} !== 5'b0 || csr_num !== 12'h0 ||
                csr_wdata !== 32'h0 || redir_pc !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d got we=%b fl=%b st=%b rv=%b mie=%b num=%h wd=%h rpc=%h want all 0",
                         i, csr_we, flush, stall, redir_valid, mie, csr_num, csr_wdata, redir_pc);
            end
        end
        exc_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || flush !== 1'b0 || mie !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got st=%b fl=%b mie=%b want 0 0 0", stall, flush, mie);
        end
    endtask

    task automatic test_irq_masked();
        irq_pending = 1'b1;
        irq_pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (flush !== 1'b0 || stall !== 1'b0 || csr_we !== 1'b0) begin
                errors++;
                $display("FAIL irq_masked cyc%0d got fl=%b st=%b we=%b want 0 0 0", i, flush, stall, csr_we);
            end
        end
        irq_pending = 1'b0;
    endtask

    task automatic test_direct_trap();
        int nrv;
        csr_mtvec = 32'h0000_0100;
        exc_valid = 1'b1;
        exc_cause = 5'd2;
        exc_pc    = 32'h0000_0040;
        exc_tval  = 32'hDEAD_BEEF;
        capture(6);
        checks++;
        if (ob_fl[0] !== 1'b1 || ob_st[0] !== 1'b1 || ob_mie[0] !== 1'b0) begin
            errors++;
            $display("FAIL direct_accept got fl=%b st=%b mie=%b want 1 1 0", ob_fl[0], ob_st[0], ob_mie[0]);
        end
        checks++;
        if (ob_we[0] !== 1'b1 || ob_num[0] !== 12'h341 || ob_wd[0] !== 32'h40) begin
            errors++;
            $display("FAIL direct_mepc got we=%b num=%h wd=%h want 1 341 00000040", ob_we[0], ob_num[0], ob_wd[0]);
        end
        checks++;
        if (ob_we[1] !== 1'b1 || ob_num[1] !== 12'h342 || ob_wd[1] !== 32'h2 || ob_fl[1] !== 1'b0) begin
            errors++;
            $display("FAIL direct_mcause got we=%b num=%h wd=%h fl=%b want 1 342 00000002 0",
                     ob_we[1], ob_num[1], ob_wd[1], ob_fl[1]);
        end
        checks++;
        if (ob_we[2] !== 1'b1 || ob_num[2] !== 12'h343 || ob_wd[2] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL direct_mtval got we=%b num=%h wd=%h want 1 343 deadbeef", ob_we[2], ob_num[2], ob_wd[2]);
        end
        checks++;
        if (ob_we[3] !== 1'b0 || ob_st[3] !== 1'b1 || ob_rv[3] !== 1'b0) begin
            errors++;
            $display("FAIL direct_rtvec got we=%b st=%b rv=%b want 0 1 0", ob_we[3], ob_st[3], ob_rv[3]);
        end
        checks++;
        if (ob_rv[4] !== 1'b1 || ob_rpc[4] !== 32'h100 || ob_st[4] !== 1'b0) begin
            errors++;
            $display("FAIL direct_redirect got rv=%b pc=%h st=%b want 1 00000100 0", ob_rv[4], ob_rpc[4], ob_st[4]);
        end
        nrv = 0;
        for (int i = 0; i < 6; i++) nrv += int'(ob_rv[i]);
        checks++;
        if (nrv != 1 || ob_st[5] !== 1'b0 || ob_mie[5] !== 1'b0) begin
            errors++;
            $display("FAIL direct_after got redirects=%0d st=%b mie=%b want 1 0 0", nrv, ob_st[5], ob_mie[5]);
        end
    endtask

    task automatic test_mret(input logic [31:0] mepc, input logic [31:0] exp_pc, input logic exp_mie);
        csr_mepc = mepc;
        mret_valid = 1'b1;
        capture(3);
        checks++;
        if (ob_fl[0] !== 1'b1 || ob_st[0] !== 1'b1 || ob_we[0] !== 1'b0 || ob_rv[0] !== 1'b0) begin
            errors++;
            $display("FAIL mret_accept got fl=%b st=%b we=%b rv=%b want 1 1 0 0", ob_fl[0], ob_st[0], ob_we[0], ob_rv[0]);
        end
        checks++;
        if (ob_rv[1] !== 1'b1 || ob_rpc[1] !== exp_pc || ob_st[1] !== 1'b0) begin
            errors++;
            $display("FAIL mret_redirect got rv=%b pc=%h st=%b want 1 %h 0", ob_rv[1], ob_rpc[1], ob_st[1], exp_pc);
        end
        checks++;
        if (ob_mie[2] !== exp_mie || ob_rv[2] !== 1'b0) begin
            errors++;
            $display("FAIL mret_mie got mie=%b rv=%b want %b 0", ob_mie[2], ob_rv[2], exp_mie);
        end
    endtask

    task automatic test_vectored_irq();
        csr_mtvec = 32'h0000_0201;
        irq_pending = 1'b1;
        irq_pc = 32'h80;
        capture(6);
        checks++;
        if (ob_wd[0] !== 32'h80 || ob_wd[1] !== 32'h8000_000B || ob_wd[2] !== 32'h0 || ob_we[2] !== 1'b1) begin
            errors++;
            $display("FAIL virq_writes got mepc=%h mcause=%h mtval=%h want 00000080 8000000b 00000000",
                     ob_wd[0], ob_wd[1], ob_wd[2]);
        end
        checks++;
        if (ob_rv[4] !== 1'b1 || ob_rpc[4] !== 32'h22C) begin
            errors++;
            $display("FAIL virq_redirect got rv=%b pc=%h want 1 0000022c", ob_rv[4], ob_rpc[4]);
        end
        checks++;
        if (ob_mie[0] !== 1'b0 || ob_mie[5] !== 1'b0) begin
            errors++;
            $display("FAIL virq_mie got %b/%b want 0/0", ob_mie[0], ob_mie[5]);
        end
        // Returning shows MPIE held the pre-trap MIE of 1
        test_mret(32'h80, 32'h80, 1'b1);
    endtask

    task automatic test_tvec_modes();
        // Exception with vectored mtvec still goes to the base
        csr_mtvec = 32'h0000_0201;
        exc_valid = 1'b1;
        exc_cause = 5'd11;
        exc_pc = 32'h200;
        exc_tval = 32'h0;
        capture(6);
        checks++;
        if (ob_rpc[4] !== 32'h200 || ob_wd[1] !== 32'hB) begin
            errors++;
            $display("FAIL mode_exc_vectored got pc=%h cause=%h want 00000200 0000000b", ob_rpc[4], ob_wd[1]);
        end
        test_mret(32'h200, 32'h200, 1'b1);
        // Vectored interrupt address wraps
        csr_mtvec = 32'hFFFF_FFFD;
        irq_pending = 1'b1;
        irq_pc = 32'h300;
        capture(6);
        checks++;
        if (ob_rpc[4] !== 32'h28 || ob_rv[4] !== 1'b1) begin
            errors++;
            $display("FAIL mode_wrap got rv=%b pc=%h want 1 00000028", ob_rv[4], ob_rpc[4]);
        end
        test_mret(32'h300, 32'h300, 1'b1);
        // Reserved mode 3 behaves as direct for interrupts
        csr_mtvec = 32'h0000_0303;
        irq_pending = 1'b1;
        irq_pc = 32'h400;
        capture(6);
        checks++;
        if (ob_rpc[4] !== 32'h300 || ob_rv[4] !== 1'b1) begin
            errors++;
            $display("FAIL mode_reserved got rv=%b pc=%h want 1 00000300", ob_rv[4], ob_rpc[4]);
        end
        test_mret(32'h400, 32'h400, 1'b1);
    endtask

    task automatic test_collision();
        int nrv;
        csr_mtvec = 32'h0000_0100;
        csr_mepc = 32'h0000_0500;
        exc_valid = 1'b1;
        mret_valid = 1'b1;
        irq_pending = 1'b1;
        irq_pc = 32'h90;
        exc_cause = 5'd11;
        exc_pc = 32'h60;
        exc_tval = 32'h0;
        capture(8);
        checks++;
        if (ob_we[0] !== 1'b1 || ob_wd[0] !== 32'h60 || ob_wd[1] !== 32'hB) begin
            errors++;
            $display("FAIL collide_trap got we=%b mepc=%h mcause=%h want 1 00000060 0000000b", ob_we[0], ob_wd[0], ob_wd[1]);
        end
        nrv = 0;
        for (int i = 0; i < 8; i++) nrv += int'(ob_rv[i]);
        checks++;
        if (nrv != 1 || ob_rpc[4] !== 32'h100 || ob_rv[4] !== 1'b1) begin
            errors++;
            $display("FAIL collide_redirect got count=%0d pc=%h want 1 00000100", nrv, ob_rpc[4]);
        end
        checks++;
        if (ob_mie[7] !== 1'b0) begin
            errors++;
            $display("FAIL collide_mie got %b want 0", ob_mie[7]);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        test_mret(32'h10, 32'h10, 1'b1);
        csr_mtvec = 32'h100;
        exc_valid = 1'b1;
        exc_cause = 5'd2;
        exc_pc = 32'h44;
        exc_tval = 32'h0;
        capture(2);
        checks++;
        if (ob_we[1] !== 1'b1 || ob_num[1] !== 12'h342) begin
            errors++;
            $display("FAIL midrst_pre got we=%b num=%h want 1 342", ob_we[1], ob_num[1]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (csr_we !== 1'b0 || stall !== 1'b0 || redir_valid !== 1'b0 || mie !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async got we=%b st=%b rv=%b mie=%b want 0 0 0 0", csr_we, stall, redir_valid, mie);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (redir_valid !== 1'b0 || csr_we !== 1'b0 || stall !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || mie !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after got bad_cycles=%0d mie=%b want 0 0", bad, mie);
        end
    endtask

    initial begin
        test_reset();
        test_irq_masked();
        test_direct_trap();
        test_mret(32'h44, 32'h44, 1'b0);
        test_mret(32'h0000_0103, 32'h100, 1'b1);
        test_vectored_irq();
        test_tvec_modes();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
